// File: rtl/hamming_pkg.sv
// Hamming(7,4) constants and helper functions shared by the scheduler and its
// syndrome core. Used with or without HAMMING_SCHED_STATS_EN.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int SYN_W  = 3;

    // s0 covers bits 6,4,2,0; s1 covers bits 5,4,1,0; s2 covers bits 3,2,1,0
    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
        logic s0;
        logic s1;
        logic s2;
        s0 = code[6] ^ code[4] ^ code[2] ^ code[0];
        s1 = code[5] ^ code[4] ^ code[1] ^ code[0];
        s2 = code[3] ^ code[2] ^ code[1] ^ code[0];
        return {s2, s1, s0};
    endfunction

    // Syndrome value s (1..7) points at bit index 7-s; zero syndrome passes through
    function automatic logic [CODE_W-1:0] hamming_correct(input logic [CODE_W-1:0] code,
                                                          input logic [SYN_W-1:0]  syn);
        logic [CODE_W-1:0] flip;
        flip = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if ((syn != '0) && (i == CODE_W - int'(syn))) begin
                flip[i] = 1'b1;
            end
        end
        return code ^ flip;
    endfunction

endpackage

// File: rtl/hamming_syndrome_core.sv
// Purely combinational Hamming(7,4) single-error-correct core. Double-bit
// errors are not detected and come out miscorrected with corr=1.
module hamming_syndrome_core
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syndrome,
    output logic [CODE_W-1:0] corrected,
    output logic              corr
);

    // Syndrome, corrected word and correction flag straight from the helpers
    always_comb begin
        syndrome  = hamming_syndrome(code);
        corrected = hamming_correct(code, syndrome);
        corr      = (syndrome != '0);
    end

endmodule

// File: rtl/hamming_rr_scheduler.sv
// Round-robin scheduler sharing one Hamming(7,4) correction core between NREQ
// requesters, with a registered valid/ready output stage tagged by lane.
// Optional saturating corrected-word counter enabled by HAMMING_SCHED_STATS_EN;
// without it err_count is tied to zero and clr_stats is ignored.
module hamming_rr_scheduler
    import hamming_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int ID_W  = 1,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [CODE_W*NREQ-1:0] req_code,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CODE_W-1:0]      out_code,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_corr,
    input  logic                   clr_stats,
    output logic [CNT_W-1:0]       err_count
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [NREQ-1:0]   grant;
    logic              found;
    logic [CODE_W-1:0] sel_code;
    logic              stage_free;
    logic              handshake;
    logic [SYN_W-1:0]  core_syn;
    logic [CODE_W-1:0] core_fixed;
    logic              core_corr;
    logic              unused_syn;
    int                best_off;
    int                off;

    // Pick the valid lane closest to rr_ptr going upward (mod NREQ) and mux its codeword
    always_comb begin
        best_off  = NREQ;
        off       = 0;
        grant_idx = '0;
        grant     = '0;
        sel_code  = '0;
        for (int i = 0; i < NREQ; i++) begin
            off = (i + NREQ - int'(rr_ptr)) % NREQ;
            if (req_valid[i] && (off < best_off)) begin
                best_off  = off;
                grant_idx = ID_W'(i);
            end
        end
        found = (best_off < NREQ);
        for (int i = 0; i < NREQ; i++) begin
            if (found && (grant_idx == ID_W'(i))) begin
                grant[i] = 1'b1;
                sel_code = req_code[CODE_W*i +: CODE_W];
            end
        end
    end

    // The stage accepts a new word when empty or when its current word leaves this cycle
    always_comb begin
        stage_free = !out_valid || out_ready;
        req_ready  = grant & {NREQ{stage_free}};
        handshake  = found && stage_free;
    end

    hamming_syndrome_core u_core (
        .code      (sel_code),
        .syndrome  (core_syn),
        .corrected (core_fixed),
        .corr      (core_corr)
    );

    assign unused_syn = ^core_syn;

    // Round-robin pointer advances past the granted lane only on a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Output register: load on handshake, drain on out_ready, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_id    <= '0;
            out_corr  <= 1'b0;
        end else if (handshake) begin
            out_valid <= 1'b1;
            out_code  <= core_fixed;
            out_id    <= grant_idx;
            out_corr  <= core_corr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef HAMMING_SCHED_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] err_cnt_q;

    // Saturating count of corrected words; a clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (clr_stats) begin
            err_cnt_q <= '0;
        end else if (handshake && core_corr && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_clr;

    assign err_count  = '0;
    assign unused_clr = clr_stats;
`endif

endmodule

// File: tb/tb_hamming_rr_scheduler.sv
// Scoreboard bench for hamming_rr_scheduler (NREQ=2, CNT_W=2). Counter
// expectations follow HAMMING_SCHED_STATS_EN when defined, else zero.
module tb_hamming_rr_scheduler;

    localparam int NREQ  = 2;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [6:0] code;
        logic [0:0] id;
        logic       corr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [7*NREQ-1:0] req_code;
    logic [NREQ-1:0]  req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_code;
    logic [0:0]       out_id;
    logic             out_corr;
    logic             clr_stats;
    logic [CNT_W-1:0] err_count;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   rr_m     = 0;
    int   cnt_m    = 0;

    hamming_rr_scheduler #(.NREQ(NREQ), .ID_W(1), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_id    (out_id),
        .out_corr  (out_corr),
        .clr_stats (clr_stats),
        .err_count (err_count)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Reference syndrome: XOR of the position numbers (7-k) of every set bit k
    function automatic logic [2:0] ref_syn(input logic [6:0] c);
        logic [2:0] s;
        s = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (c[k]) s = s ^ 3'(7 - k);
        end
        return s;
    endfunction

    function automatic exp_t ref_out(input logic [6:0] c, input int lane);
        exp_t e;
        logic [2:0] s;
        logic [6:0] f;
        s = ref_syn(c);
        f = 7'd0;
        if (s != 3'd0) f[7 - int'(s)] = 1'b1;
        e.code = c ^ f;
        e.id   = 1'(lane);
        e.corr = (s != 3'd0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check mid-cycle against the model, then advance the model
    task automatic applyStimulus(input logic [1:0] v, input logic [6:0] c0, input logic [6:0] c1,
                                 input logic ordy, input logic clr, input logic rs);
        logic [1:0] exp_rdy;
        bit         stage_free;
        int         lane;
        int         idx;
        logic [6:0] lc;
        logic [2:0] s;
        req_valid = v;
        req_code  = {c1, c0};
        out_ready = ordy;
        clr_stats = clr;
        rst       = rs;
        #4;
        if (!rs) begin
            checkOutput("out_valid", 32'(out_valid), 32'(sb.size() > 0));
            stage_free = (sb.size() == 0) || ordy;
            exp_rdy = 2'b00;
            lane = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr_m + k) % NREQ;
                if (lane < 0 && v[idx]) lane = idx;
            end
            if (lane >= 0 && stage_free) exp_rdy[lane] = 1'b1;
            checkOutput("req_ready", 32'(req_ready), 32'(exp_rdy));
            checkOutput("err_count", 32'(err_count), 32'(cnt_m));
            if (sb.size() > 0) begin
                checkOutput("out_code", 32'(out_code), 32'(sb[0].code));
                checkOutput("out_id",   32'(out_id),   32'(sb[0].id));
                checkOutput("out_corr", 32'(out_corr), 32'(sb[0].corr));
                if (ordy) void'(sb.pop_front());
            end
            s = 3'd0;
            if (exp_rdy != 2'b00) begin
                lc = (lane == 0) ? c0 : c1;
                s  = ref_syn(lc);
                sb.push_back(ref_out(lc, lane));
                rr_m = (lane + 1) % NREQ;
            end
`ifdef HAMMING_SCHED_STATS_EN
            if (clr) cnt_m = 0;
            else if (exp_rdy != 2'b00 && s != 3'd0 && cnt_m < (1 << CNT_W) - 1) cnt_m++;
`endif
        end
        @(posedge clk);
        #1;
        if (rs) begin
            sb.delete();
            rr_m  = 0;
            cnt_m = 0;
        end
    endtask

    initial begin
        req_valid = '0;
        req_code  = '0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        rst       = 1'b1;

        // Reset state
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_code",  32'(out_code),  32'd0);
        checkOutput("rst_out_id",    32'(out_id),    32'd0);
        checkOutput("rst_out_corr",  32'(out_corr),  32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);

        // Clean word on lane 0, then single errors at syndrome 1 and 7 on lane 1
        applyStimulus(2'b01, 7'b0000000, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 7'd0, 7'b1000000, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 7'd0, 7'b0000001, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);

        // Both lanes valid: strict rotation at one word per cycle
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'b11, 7'(i * 13), 7'(i * 29 + 5), 1'b1, 1'b0, 1'b0);
        end

        // Backpressure for three cycles, then release with both lanes waiting
        applyStimulus(2'b11, 7'b0110011, 7'b1010101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 7'b0110011, 7'b1010101, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(2'b11, 7'b0110011, 7'b1010101, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);

        // Five erroneous words to saturate the counter, then clear alongside an error
        applyStimulus(2'b01, 7'b0000100, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 7'b0010000, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 7'b0000010, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 7'b1000000, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 7'b0001000, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 7'b0100000, 7'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic with random backpressure
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 7'($urandom), 7'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        end
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);

        // Reset while a word is stalled: it is dropped and arbitration restarts at lane 0
        applyStimulus(2'b10, 7'd0, 7'b0000110, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_out_code",  32'(out_code),  32'd0);
        checkOutput("mid_rst_err_count", 32'(err_count), 32'd0);
        applyStimulus(2'b11, 7'b1111111, 7'b0000111, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0);

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
